// File: rtl/ram_arb_pkg.sv
// Shared definitions for the three-port expansion-RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NPORTS     = 3;
    localparam logic [1:0]  GRANT_NONE = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    // Round-robin partner of the last granted port among 1/2.
    function automatic logic [1:0] rr_other(input logic [1:0] last);
        return (last == 2'd1) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational winner select: port 0 fixed priority, ports 1/2 round-robin,
// starvation override hands the slot to 1/2 when port 0 has dominated too long.
module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] pending,
    input  logic [1:0]        rr_last,
    input  logic              starved,
    output logic [1:0]        winner,
    output logic              valid
);

    logic       others;
    logic [1:0] rr_win;

    always_comb begin
        others = pending[1] | pending[2];
        valid  = |pending;

        if (pending[1] && pending[2]) begin
            rr_win = rr_other(rr_last);
        end else if (pending[1]) begin
            rr_win = 2'd1;
        end else begin
            rr_win = 2'd2;
        end

        winner = GRANT_NONE;
        if (starved && others) begin
            winner = rr_win;
        end else if (pending[0]) begin
            winner = 2'd0;
        end else if (others) begin
            winner = rr_win;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises DMA / cartridge-window / host-loader accesses onto one RAM
// controller port; all ports use the req != ack toggle handshake.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ram_a_bits   = 17,
    parameter int unsigned starve_limit = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ram_a_bits-1:0] p0_a,
    input  logic [7:0]            p0_d,
    input  logic                  p0_we,
    input  logic                  p0_req,
    output logic                  p0_ack,
    output logic [7:0]            p0_q,
    input  logic [ram_a_bits-1:0] p1_a,
    input  logic [7:0]            p1_d,
    input  logic                  p1_we,
    input  logic                  p1_req,
    output logic                  p1_ack,
    output logic [7:0]            p1_q,
    input  logic [ram_a_bits-1:0] p2_a,
    input  logic [7:0]            p2_d,
    input  logic                  p2_we,
    input  logic                  p2_req,
    output logic                  p2_ack,
    output logic [7:0]            p2_q,
    output logic [ram_a_bits-1:0] mem_a,
    output logic [7:0]            mem_d,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_q,
    output logic [1:0]            grant
);

    localparam logic [3:0] STARVE_MAX = 4'(starve_limit);

    logic [NPORTS-1:0]                 port_req;
    logic [NPORTS-1:0]                 pending;
    logic [NPORTS-1:0][ram_a_bits-1:0] port_a;
    logic [NPORTS-1:0][7:0]            port_d;
    logic [NPORTS-1:0]                 port_we;

    arb_state_e                        state_q, state_d;
    logic [ram_a_bits-1:0]             mem_a_q, mem_a_d;
    logic [7:0]                        mem_d_q, mem_d_d;
    logic                              mem_we_q, mem_we_d;
    logic                              mem_req_q, mem_req_d;
    logic [1:0]                        grant_q, grant_d;
    logic [3:0]                        starv_q, starv_d;
    logic [1:0]                        rr_last_q, rr_last_d;
    logic [NPORTS-1:0]                 ack_q, ack_d;
    logic [NPORTS-1:0][7:0]            rdata_q, rdata_d;

    logic                              starved;
    logic                              others;
    logic [1:0]                        winner;
    logic                              win_valid;

    assign port_req = {p2_req, p1_req, p0_req};
    assign port_a   = {p2_a, p1_a, p0_a};
    assign port_d   = {p2_d, p1_d, p0_d};
    assign port_we  = {p2_we, p1_we, p0_we};
    assign pending  = port_req ^ ack_q;
    assign starved  = (starv_q == STARVE_MAX);
    assign others   = pending[1] | pending[2];

    rr_pick u_rr_pick (
        .pending (pending),
        .rr_last (rr_last_q),
        .starved (starved),
        .winner  (winner),
        .valid   (win_valid)
    );

    always_comb begin
        state_d   = state_q;
        mem_a_d   = mem_a_q;
        mem_d_d   = mem_d_q;
        mem_we_d  = mem_we_q;
        mem_req_d = mem_req_q;
        grant_d   = grant_q;
        starv_d   = starv_q;
        rr_last_d = rr_last_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    mem_a_d   = port_a[winner];
                    mem_d_d   = port_d[winner];
                    mem_we_d  = port_we[winner];
                    mem_req_d = ~mem_req_q;
                    grant_d   = winner;
                    state_d   = ST_WAIT;
                    // Count only port-0 wins that actually held someone else off.
                    if (winner == 2'd0) begin
                        if (!others) begin
                            starv_d = '0;
                        end else if (!starved) begin
                            starv_d = starv_q + 4'd1;
                        end
                    end else begin
                        starv_d   = '0;
                        rr_last_d = winner;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack == mem_req_q) begin
                    if (!mem_we_q) begin
                        rdata_d[grant_q] = mem_q;
                    end
                    ack_d[grant_q] = ~ack_q[grant_q];
                    grant_d        = GRANT_NONE;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            mem_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            grant_q   <= GRANT_NONE;
            starv_q   <= '0;
            rr_last_q <= 2'd2;
            ack_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
            mem_we_q  <= mem_we_d;
            mem_req_q <= mem_req_d;
            grant_q   <= grant_d;
            starv_q   <= starv_d;
            rr_last_q <= rr_last_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign p0_ack  = ack_q[0];
    assign p1_ack  = ack_q[1];
    assign p2_ack  = ack_q[2];
    assign p0_q    = rdata_q[0];
    assign p1_q    = rdata_q[1];
    assign p2_q    = rdata_q[2];
    assign mem_a   = mem_a_q;
    assign mem_d   = mem_d_q;
    assign mem_we  = mem_we_q;
    assign mem_req = mem_req_q;
    assign grant   = grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM controller.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned AW = 17;
    localparam int unsigned SL = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic          we;
        logic [7:0]    q;
    } txn_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] pa [3];
    logic [7:0]    pd [3];
    logic [2:0]    pwe;
    logic [2:0]    preq;
    logic          p0_ack, p1_ack, p2_ack;
    logic [7:0]    p0_q, p1_q, p2_q;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_d;
    logic          mem_we, mem_req;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_q   = 8'h00;
    logic [1:0]    grant;
    logic [2:0]    acks;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   n_mreq   = 0;
    int unsigned   ctrl_lat = 1;
    logic [1:0]    exp_grant [$];
    txn_t          q0 [$];
    txn_t          q1 [$];
    txn_t          q2 [$];
    logic [7:0]    last_q [3];
    logic [7:0]    ref_wr [int];
    logic [7:0]    cmem [int];

    assign acks = {p2_ack, p1_ack, p0_ack};

    ram_port_arbiter #(.ram_a_bits(AW), .starve_limit(SL)) dut (
        .clk(clk), .reset_n(rst_n),
        .p0_a(pa[0]), .p0_d(pd[0]), .p0_we(pwe[0]), .p0_req(preq[0]), .p0_ack(p0_ack), .p0_q(p0_q),
        .p1_a(pa[1]), .p1_d(pd[1]), .p1_we(pwe[1]), .p1_req(preq[1]), .p1_ack(p1_ack), .p1_q(p1_q),
        .p2_a(pa[2]), .p2_d(pd[2]), .p2_we(pwe[2]), .p2_req(preq[2]), .p2_ack(p2_ack), .p2_q(p2_q),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_q(mem_q), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : init_val(a);
    endfunction

    function automatic logic [7:0] get_q(input int p);
        case (p)
            0:       return p0_q;
            1:       return p1_q;
            default: return p2_q;
        endcase
    endfunction

    function automatic int qsize(input int p);
        case (p)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic txn_t qpeek(input int p);
        case (p)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int p, input txn_t t);
        case (p)
            0:       q0.push_back(t);
            1:       q1.push_back(t);
            default: q2.push_back(t);
        endcase
    endtask

    task automatic qpop(input int p, output txn_t t);
        case (p)
            0:       t = q0.pop_front();
            1:       t = q1.pop_front();
            default: t = q2.pop_front();
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural controller: acks after ctrl_lat edges, read data valid with the ack.
    initial begin
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mem_ack <= 1'b0;
                cnt = 0;
            end else if (mem_req != mem_ack) begin
                cnt++;
                if (cnt >= ctrl_lat) begin
                    cnt = 0;
                    if (mem_we) begin
                        cmem[int'(mem_a)] = mem_d;
                    end else begin
                        mem_q <= cmem.exists(int'(mem_a)) ? cmem[int'(mem_a)] : init_val(mem_a);
                    end
                    mem_ack <= ~mem_ack;
                end
            end
        end
    end

    task automatic on_issue();
        logic [1:0] g;
        txn_t       t;
        g = grant;
        if (exp_grant.size() == 0) begin
            check("grant_unexpected", 32'(exp_grant.size()), 32'd1);
        end else begin
            check("grant_order", 32'(g), 32'(exp_grant.pop_front()));
        end
        if (g < 2'd3) begin
            if (qsize(int'(g)) == 0) begin
                check("txn_missing", 32'(qsize(int'(g))), 32'd1);
            end else begin
                t = qpeek(int'(g));
                check("mem_a", 32'(mem_a), 32'(t.a));
                check("mem_we", 32'(mem_we), 32'(t.we));
                if (t.we) check("mem_d", 32'(mem_d), 32'(t.d));
            end
        end
    endtask

    task automatic on_done(input int p);
        txn_t t;
        if (qsize(p) == 0) begin
            check("ack_unexpected", 32'(qsize(p)), 32'd1);
        end else begin
            qpop(p, t);
            check($sformatf("p%0d_q", p), 32'(get_q(p)), 32'(t.q));
            check($sformatf("p%0d_ack_eq_req", p), 32'(acks[p]), 32'(preq[p]));
        end
    endtask

    initial begin
        logic       prev_mreq;
        logic [2:0] prev_ack;
        prev_mreq = 1'b0;
        prev_ack  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req != prev_mreq) begin
                    n_mreq++;
                    on_issue();
                end
                for (int p = 0; p < 3; p++) begin
                    if (acks[p] != prev_ack[p]) on_done(p);
                end
            end
            prev_mreq = mem_req;
            prev_ack  = acks;
        end
    end

    task automatic issue(input int p, input logic [AW-1:0] a, input logic [7:0] d, input logic we);
        txn_t t;
        int   n;
        n = 0;
        @(negedge clk);
        while (preq[p] != acks[p] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("issue_wait", 32'(preq[p] ^ acks[p]), 32'd0);
        pa[p]  = a;
        pd[p]  = d;
        pwe[p] = we;
        t.a  = a;
        t.d  = d;
        t.we = we;
        if (we) begin
            ref_wr[int'(a)] = d;
            t.q = last_q[p];
        end else begin
            t.q       = ref_rd(a);
            last_q[p] = t.q;
        end
        qpush(p, t);
        preq[p] = ~preq[p];
    endtask

    task automatic flush();
        exp_grant.delete();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int p = 0; p < 3; p++) last_q[p] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        preq  = '0;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((preq ^ acks) != 3'b000 || mem_req != mem_ack) && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_pending", 32'(preq ^ acks), 32'd0);
        check("grant_idle", 32'(grant), 32'(GRANT_NONE));
        check("grant_left", 32'(exp_grant.size()), 32'd0);
        check("txn_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_grant", 32'(grant), 32'(GRANT_NONE));
        check("rst_acks", 32'(acks), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_mem_d", 32'(mem_d), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_pq", {8'h00, p2_q, p1_q, p0_q}, 32'd0);
    endtask

    initial begin
        int          n;
        int unsigned n0;
        for (int p = 0; p < 3; p++) begin
            pa[p]     = '0;
            pd[p]     = '0;
            last_q[p] = 8'h00;
        end
        pwe  = '0;
        preq = '0;
        cmem[int'(17'h12345)]   = 8'hA5;
        ref_wr[int'(17'h12345)] = 8'hA5;

        #1 rst_n = 1'b0;
        #2 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single read on port 1, two-cycle controller
        ctrl_lat = 2;
        exp_grant.push_back(2'd1);
        issue(1, 17'h12345, 8'h00, 1'b0);
        drain();

        // Port 0: read, write (q unchanged), read back the write
        ctrl_lat = 1;
        exp_grant.push_back(2'd0);
        issue(0, 17'h00020, 8'h00, 1'b0);
        drain();
        n0 = n_mreq;
        exp_grant.push_back(2'd0);
        issue(0, 17'h00010, 8'h3C, 1'b1);
        drain();
        check("write_mreq_count", n_mreq - n0, 32'd1);
        exp_grant.push_back(2'd0);
        issue(0, 17'h00010, 8'h00, 1'b0);
        drain();

        // Minimum client latency with a one-cycle controller
        exp_grant.push_back(2'd0);
        issue(0, 17'h00040, 8'h00, 1'b0);
        n = 0;
        while (preq[0] != acks[0] && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check("latency_edges", 32'(n), 32'd3);
        drain();

        // Ports 1 and 2 together, four rounds
        do_reset();
        for (int r = 0; r < 4; r++) begin
            exp_grant.push_back(2'd1);
            exp_grant.push_back(2'd2);
            fork
                issue(1, 17'(17'h00100 + r), 8'h00, 1'b0);
                issue(2, 17'(17'h00180 + r), 8'h00, 1'b0);
            join
            drain();
        end

        // Port 0 hammering while port 2 waits
        do_reset();
        exp_grant.push_back(2'd0);
        exp_grant.push_back(2'd0);
        exp_grant.push_back(2'd0);
        exp_grant.push_back(2'd0);
        exp_grant.push_back(2'd2);
        exp_grant.push_back(2'd0);
        fork
            issue(2, 17'h00233, 8'h00, 1'b0);
            begin
                for (int i = 0; i < 5; i++) issue(0, 17'(17'h00300 + i), 8'h00, 1'b0);
            end
        join
        drain();

        // All three at once
        do_reset();
        exp_grant.push_back(2'd0);
        exp_grant.push_back(2'd1);
        exp_grant.push_back(2'd2);
        fork
            issue(0, 17'h00411, 8'h00, 1'b0);
            issue(1, 17'h00422, 8'h00, 1'b0);
            issue(2, 17'h00433, 8'h00, 1'b0);
        join
        drain();

        // Reset during an in-flight access
        do_reset();
        exp_grant.push_back(2'd2);
        issue(2, 17'h00077, 8'h00, 1'b0);
        drain();
        ctrl_lat = 8;
        exp_grant.push_back(2'd1);
        issue(1, 17'h1ABCD, 8'h00, 1'b0);
        n = 0;
        while (grant != 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_state_grant", 32'(grant), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        preq = '0;
        #1 check_reset_outputs();
        flush();
        n0 = n_mreq;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_acks", 32'(acks), 32'd0);
        check("post_rst_grant", 32'(grant), 32'(GRANT_NONE));
        check("post_rst_mreq_count", n_mreq - n0, 32'd0);
        check("post_rst_ack_q_left", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
